imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL be the immediate output width; legal values are 32 and 64 only.
REQ-002 Parameter AUTO_DECODE, default 0, SHALL select the format source: 0 = ImmSrc port, 1 = opcode field Instr[6:0].
REQ-003 Parameter TAGW, default 4, SHALL be the width of the sideband tag carried alongside each immediate.
REQ-004 clk  input  1  rising-edge clock; the block has one clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 Instr  input  32  instruction word.
REQ-007 ImmSrc  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal; ignored when AUTO_DECODE=1.
REQ-008 InTag  input  TAGW  sideband tag, passed through unchanged.
REQ-009 InValid  input  1  upstream request valid.
REQ-010 InReady  output  1  block can accept a request this cycle.
REQ-011 ImmExt  output  XLEN  sign-extended immediate at the FIFO head.
REQ-012 OutTag  output  TAGW  tag at the FIFO head.
REQ-013 ImmErr  output  1  the head entry had an illegal format.
REQ-014 OutValid  output  1  head entry is valid.
REQ-015 OutReady  input  1  downstream accepts the head entry.

Function
REQ-016 Decode SHALL produce: I = sext(Instr[31:20]); S = sext({Instr[31:25],Instr[11:7]}); B = sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}); U = sext({Instr[31:12],12'b0}); J = sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}).
REQ-017 Sign extension SHALL replicate Instr[31] up to bit XLEN-1 for every format, including U.
REQ-018 When AUTO_DECODE=1, the format SHALL come from the opcode: 0010011, 0000011 and 1100111 give I; 0100011 gives S; 1100011 gives B; 0110111 and 0010111 give U; 1101111 gives J; every other opcode is illegal.
REQ-019 An illegal format SHALL store ImmExt = 0 with ImmErr = 1; a legal format SHALL store ImmErr = 0.
REQ-020 Storage SHALL be a 2-entry FIFO holding {ImmExt, InTag, ImmErr}, with occupancy count 0..2.
REQ-021 InReady SHALL be high when count < 2, driven combinationally from registered state only; it SHALL NOT depend on OutReady.
REQ-022 A push SHALL occur on a rising edge with InValid && InReady.
REQ-023 A pop SHALL occur on a rising edge with OutValid && OutReady.
REQ-024 OutValid SHALL equal (count != 0); ImmExt, OutTag and ImmErr SHALL show the head entry.
REQ-025 Latency SHALL be 1 cycle: a request accepted at edge N is visible on the outputs after edge N.
REQ-026 Throughput SHALL be 1 request per cycle whenever OutReady is held high.
REQ-027 Simultaneous push and pop at count 1 SHALL leave count at 1, with the new entry becoming the head after the edge.
REQ-028 Push and pop SHALL never coincide at count 2, because InReady is low there.
REQ-029 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-030 Head outputs SHALL remain stable while OutValid && !OutReady.

Reset
REQ-031 Asserting rst_n low SHALL, asynchronously: set count = 0 and both pointers = 0; drive OutValid = 0, ImmExt = 0, OutTag = 0, ImmErr = 0; drive InReady = 1 after reset release.
REQ-032 Reset mid-operation SHALL discard all stored entries; no entry SHALL reappear after release.

Structure
REQ-033 The ImmSrc encodings, the opcode constants and the legal XLEN values SHALL live in the shared core package.
REQ-034 Combinational decode SHALL be one sub-module, imm_decode, taking Instr, ImmSrc and AUTO_DECODE and producing the immediate and an illegal flag.
REQ-035 The FIFO SHALL be implemented inline in imm_extend_pipe.

Verification
REQ-036 XLEN=32, ImmSrc=000, Instr=0xFFF00093, OutReady=1: next cycle ImmExt=0xFFFFFFFF, ImmErr=0.
REQ-037 XLEN=64, ImmSrc=011, Instr=0x800002B7: ImmExt=0xFFFFFFFF80000000.
REQ-038 AUTO_DECODE=1, Instr=0x0000006F (J-type), then Instr=0x0000007F (illegal opcode): first ImmExt=0, ImmErr=0; second ImmExt=0, ImmErr=1.
REQ-039 OutReady=0 with 3 back-to-back pushes of tags 1,2,3: InReady drops after 2 accepts; tag 3 is held off; raising OutReady then delivers tags 1, 2, 3 in order with no loss.
REQ-040 Continuous InValid=OutReady=1 for 8 cycles with tags 0..7: OutValid high from cycle 1 onward and one output per cycle in order.
REQ-041 rst_n pulsed low at count=2: OutValid=0 immediately; after release InReady=1 and no stale tags are emitted.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// imm_extend_pipe_pkg: shared definitions for the immediate-extend pipeline.
//   imm_src_e   - immediate format select encodings (ImmSrc port values)
//   OPC_*       - RV32 major opcodes that carry an immediate
//   XLEN_32/64  - the only supported immediate output widths
//   opc_to_src  - opcode -> format mapping used when AUTO_DECODE=1
package imm_extend_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_BAD = 3'b111   // 101/110 are illegal as well
  } imm_src_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

  function automatic imm_src_e opc_to_src(input logic [6:0] opc);
    imm_src_e s;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: s = IMM_I;
      OPC_STORE:                      s = IMM_S;
      OPC_BRANCH:                     s = IMM_B;
      OPC_LUI, OPC_AUIPC:             s = IMM_U;
      OPC_JAL:                        s = IMM_J;
      default:                        s = IMM_BAD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/imm_extend_pipe_imm_decode.sv
// imm_decode: combinational RV immediate extraction + sign extension.
//   instr_i   [31:0]     instruction word
//   imm_src_i [2:0]      format select (ignored when AUTO_DECODE=1)
//   imm_o     [XLEN-1:0] sign-extended immediate, 0 when illegal
//   illegal_o            format was illegal
module imm_decode
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  imm_src_e           src;
  logic signed [31:0] imm32;

  always_comb begin
    src       = AUTO_DECODE ? opc_to_src(instr_i[6:0]) : imm_src_e'(imm_src_i);
    imm32     = '0;
    illegal_o = 1'b0;
    case (src)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: begin
        imm32     = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

  // imm32[31] equals instr_i[31] for every legal format, so a signed
  // widening cast replicates the instruction sign bit up to XLEN-1.
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate decode feeding a 2-entry output FIFO.
//   clk, rst_n           clock, async active-low reset
//   Instr, ImmSrc, InTag request payload; InValid/InReady handshake
//   ImmExt, OutTag, ImmErr head entry; OutValid/OutReady handshake
// InReady depends only on registered occupancy, so upstream never sees a
// combinational path from OutReady.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN        = XLEN_32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int TAGW        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic [TAGW-1:0] InTag,
  input  logic            InValid,
  output logic            InReady,
  output logic [XLEN-1:0] ImmExt,
  output logic [TAGW-1:0] OutTag,
  output logic            ImmErr,
  output logic            OutValid,
  input  logic            OutReady
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAGW-1:0] tag;
    logic            err;
  } entry_t;

  entry_t          new_entry;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_dec (
    .instr_i   (Instr),
    .imm_src_i (ImmSrc),
    .imm_o     (dec_imm),
    .illegal_o (dec_err)
  );

  assign new_entry = '{imm: dec_imm, tag: InTag, err: dec_err};

  entry_t     mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;
  entry_t     head;

  assign InReady  = (count_q < 2'd2);
  assign OutValid = (count_q != 2'd0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  always_comb begin
    count_d  = count_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Outputs are forced to zero while empty so stale slots never leak out.
  assign head   = mem_q[rd_ptr_q];
  assign ImmExt = OutValid ? head.imm : '0;
  assign OutTag = OutValid ? head.tag : '0;
  assign ImmErr = OutValid ? head.err : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = '0;
  logic [2:0]  ImmSrc = '0;
  logic [3:0]  InTag = '0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b1;

  // index 0: XLEN=32 port-select, 1: XLEN=64 port-select, 2: XLEN=32 auto
  logic [2:0]       ir, ov, err_o;
  logic [2:0][3:0]  tag_o;
  logic [2:0][63:0] imm_o;
  logic [31:0]      imm0, imm2;
  logic [63:0]      imm1;

  assign imm_o[0] = {32'b0, imm0};
  assign imm_o[1] = imm1;
  assign imm_o[2] = {32'b0, imm2};

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAGW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
    .InValid(InValid), .InReady(ir[0]), .ImmExt(imm0), .OutTag(tag_o[0]),
    .ImmErr(err_o[0]), .OutValid(ov[0]), .OutReady(OutReady));
  imm_extend_pipe #(.XLEN(64), .AUTO_DECODE(1'b0), .TAGW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
    .InValid(InValid), .InReady(ir[1]), .ImmExt(imm1), .OutTag(tag_o[1]),
    .ImmErr(err_o[1]), .OutValid(ov[1]), .OutReady(OutReady));
  imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAGW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
    .InValid(InValid), .InReady(ir[2]), .ImmExt(imm2), .OutTag(tag_o[2]),
    .ImmErr(err_o[2]), .OutValid(ov[2]), .OutReady(OutReady));

  typedef struct packed {
    logic [2:0][63:0] imm;
    logic [2:0]       err;
    logic [3:0]       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the format table; width 32 results are
  // zero-padded to 64 for comparison.
  task automatic model(input logic [31:0] ins, input logic [2:0] src_in, input bit auto,
                       input bit x64, output logic [63:0] imm, output logic err);
    logic [2:0]  s;
    logic [31:0] v;
    s = src_in;
    if (auto) begin
      case (ins[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: s = 3'd0;
        7'b0100011:                         s = 3'd1;
        7'b1100011:                         s = 3'd2;
        7'b0110111, 7'b0010111:             s = 3'd3;
        7'b1101111:                         s = 3'd4;
        default:                            s = 3'd7;
      endcase
    end
    err = 1'b0;
    v   = '0;
    case (s)
      3'd0: v = {{20{ins[31]}}, ins[31:20]};
      3'd1: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: v = {ins[31:12], 12'h000};
      3'd4: v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: begin v = '0; err = 1'b1; end
    endcase
    imm = x64 ? {{32{ins[31] & ~err}}, v} : {32'b0, v};
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [2:0] src,
                     input logic [3:0] tag, input logic ordy);
    InValid = v; Instr = ins; ImmSrc = src; InTag = tag; OutReady = ordy;
  endtask

  // Called just after a falling edge with inputs settled: checks every DUT
  // against the scoreboard, then advances one clock and updates it.
  task automatic tick();
    exp_t        e;
    logic        push, pop;
    logic [63:0] m;
    logic        me;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovalid%0d", i), 64'(ov[i]), 64'(sb.size() != 0));
      chk($sformatf("iready%0d", i), 64'(ir[i]), 64'(sb.size() < 2));
      if (sb.size() != 0) begin
        chk($sformatf("imm%0d", i), imm_o[i], sb[0].imm[i]);
        chk($sformatf("tag%0d", i), 64'(tag_o[i]), 64'(sb[0].tag));
        chk($sformatf("err%0d", i), 64'(err_o[i]), 64'(sb[0].err[i]));
      end
    end
    push = InValid && (sb.size() < 2);
    pop  = (sb.size() != 0) && OutReady;
    model(Instr, ImmSrc, 1'b0, 1'b0, m, me); e.imm[0] = m; e.err[0] = me;
    model(Instr, ImmSrc, 1'b0, 1'b1, m, me); e.imm[1] = m; e.err[1] = me;
    model(Instr, ImmSrc, 1'b1, 1'b0, m, me); e.imm[2] = m; e.err[2] = me;
    e.tag = InTag;
    @(posedge clk);
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_zero_out(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_ov%0d", tag, i), 64'(ov[i]), 64'd0);
      chk($sformatf("%s_imm%0d", tag, i), imm_o[i], 64'd0);
      chk($sformatf("%s_tag%0d", tag, i), 64'(tag_o[i]), 64'd0);
      chk($sformatf("%s_err%0d", tag, i), 64'(err_o[i]), 64'd0);
    end
  endtask

  logic [31:0] tbl [8];

  initial begin
    tbl[0] = 32'h00A12023; tbl[1] = 32'hFE5FF06F; tbl[2] = 32'h80000063;
    tbl[3] = 32'h7FFFF0B7; tbl[4] = 32'hFFF5C513; tbl[5] = 32'h12345697;
    tbl[6] = $urandom;     tbl[7] = $urandom;

    // reset state
    #12;
    chk_zero_out("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // I-type, all-ones immediate
    drv(1'b1, 32'hFFF00093, 3'd0, 4'd1, 1'b1);
    tick();
    drv(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    chk("i_imm32", imm_o[0], 64'h00000000FFFFFFFF);
    chk("i_err32", 64'(err_o[0]), 64'd0);
    chk("i_imm64", imm_o[1], 64'hFFFFFFFFFFFFFFFF);
    tick();

    // U-type with sign bit set
    drv(1'b1, 32'h800002B7, 3'd3, 4'd2, 1'b1);
    tick();
    drv(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    chk("u_imm64", imm_o[1], 64'hFFFFFFFF80000000);
    chk("u_imm32", imm_o[0], 64'h0000000080000000);
    chk("u_auto", imm_o[2], 64'h0000000080000000);
    tick();

    // auto decode: JAL then illegal opcode, back to back at count 1
    drv(1'b1, 32'h0000006F, 3'd4, 4'd3, 1'b1);
    tick();
    chk("jal_imm", imm_o[2], 64'd0);
    chk("jal_err", 64'(err_o[2]), 64'd0);
    drv(1'b1, 32'h0000007F, 3'd4, 4'd4, 1'b1);
    tick();
    chk("bad_opc_imm", imm_o[2], 64'd0);
    chk("bad_opc_err", 64'(err_o[2]), 64'd1);
    chk("bad_opc_tag", 64'(tag_o[2]), 64'd4);

    // illegal ImmSrc encodings
    for (int s = 5; s < 8; s++) begin
      drv(1'b1, 32'hFFFFFFFF, 3'(s), 4'(s), 1'b1);
      tick();
      chk($sformatf("bad_src%0d_err", s), 64'(err_o[0]), 64'd1);
      chk($sformatf("bad_src%0d_imm", s), imm_o[1], 64'd0);
    end

    // format sweep with random valid / back-pressure
    for (int k = 0; k < 40; k++) begin
      drv(1'($urandom_range(0, 3) != 0), tbl[k % 8], 3'(k % 5), 4'(k),
          1'($urandom_range(0, 3) != 0));
      tick();
    end
    drv(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    repeat (3) tick();

    // fill to 2 with OutReady low; third request held off
    drv(1'b1, tbl[1], 3'd4, 4'd1, 1'b0); tick();
    drv(1'b1, tbl[2], 3'd2, 4'd2, 1'b0); tick();
    chk("full_iready", 64'(ir[0]), 64'd0);
    drv(1'b1, tbl[0], 3'd1, 4'd3, 1'b0); tick();
    tick();
    chk("hold_tag", 64'(tag_o[0]), 64'd1);
    OutReady = 1'b1;
    tick();
    tick();
    drv(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    repeat (3) tick();

    // streaming: one result per cycle in order
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, tbl[k], 3'(k % 5), 4'(k), 1'b1);
      tick();
      chk($sformatf("stream_ov%0d", k), 64'(ov[0]), 64'd1);
      chk($sformatf("stream_tag%0d", k), 64'(tag_o[0]), 64'(k));
    end
    drv(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    tick();
    tick();

    // reset while full
    drv(1'b1, tbl[4], 3'd0, 4'd9, 1'b0); tick();
    drv(1'b1, tbl[5], 3'd3, 4'd10, 1'b0); tick();
    chk("pre_rst_ov", 64'(ov[0]), 64'd1);
    InValid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero_out("midrst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    OutReady = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
